// File: rtl/cnnout_ctrl.sv
// cnnout_ctrl: write/read sequencer for the multi-channel CNN output buffer bank
module cnnout_ctrl #(
  parameter int NCH = 8,
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              global_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_len,
  input  logic              in_valid,
  input  logic              out_ready,
  output logic              write_start,
  output logic              write_valid,
  output logic [ADDR_W-1:0] writeaddr1,
  output logic              end_write,
  output logic              read_start,
  output logic [5:0]        i,
  output logic [ADDR_W-1:0] readaddrram,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_OUT, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] len, len_m1, wcnt, wnext, raddr;
  logic [5:0] ch;
  logic [1:0] lat;
  logic rd, is_last;
  assign wnext = wcnt + 1'b1;
  assign len_m1 = len - 1'b1;
  assign rd = state inside {RD_ISSUE, RD_WAIT, RD_OUT};
  assign is_last = ch == 6'(NCH - 1) && raddr == len_m1;
  assign i = rd ? ch : '0;
  assign readaddrram = rd ? raddr : '0;
  assign writeaddr1 = state == WRITE ? wnext : '0;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) state <= IDLE;
    else state <= state_n;
  end
  // next state and combinational bank strobes
  always_comb begin
    state_n = state;
    write_start = 1'b0;
    write_valid = 1'b0;
    end_write = 1'b0;
    read_start = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (start) state_n = frame_len != '0 ? WRITE : DONE;
      WRITE: begin
        write_start = 1'b1;
        write_valid = in_valid;
        end_write = in_valid && wnext == len;
        if (end_write) state_n = RD_ISSUE;
      end
      RD_ISSUE: begin
        read_start = 1'b1;
        state_n = RD_LAT == 1 ? RD_OUT : RD_WAIT;
      end
      RD_WAIT: if (lat == '0) state_n = RD_OUT;
      RD_OUT: if (out_ready) state_n = is_last ? DONE : RD_ISSUE;
      DONE: begin
        done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // frame length, write/read counters, latency wait and registered output tags
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      len <= '0;
      wcnt <= '0;
      raddr <= '0;
      ch <= '0;
      lat <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        len <= frame_len;
        wcnt <= '0;
      end
      if (state == WRITE && in_valid) wcnt <= wnext;
      if (end_write) begin
        ch <= '0;
        raddr <= '0;
      end
      if (state == RD_ISSUE) lat <= 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);
      if (state == RD_WAIT && lat != '0) lat <= lat - 1'b1;
      if (state == RD_OUT && out_ready && !is_last) begin
        raddr <= raddr == len_m1 ? '0 : raddr + 1'b1;
        if (raddr == len_m1) ch <= ch + 1'b1;
      end
      out_valid <= state_n == RD_OUT;
      out_last <= state_n == RD_OUT && is_last;
    end
  end
endmodule
